vga_bw_fb_reader: RTL and testbench

1-bpp framebuffer scan-out stage between the 640x480 timing generator and the VGA pins. It holds a 160x120 monochrome bitmap in on-chip dual-port RAM and takes pixel coordinates, active flag and syncs from the timing core. It produces a pixel-doubled (x4 in each axis) video bit with syncs re-aligned to the RAM read latency. A host-side write port updates the bitmap at any time, independent of scan-out.

---
 rtl/vga_bw_pkg.sv | 23 ++
 rtl/vga_bw_fb_ram.sv | 31 +++
 rtl/vga_bw_fb_reader.sv | 107 ++++++++++
 tb/tb_vga_bw_fb_reader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_bw_pkg.sv
// Shared constants and types for the 1-bpp VGA framebuffer scan-out stage.
// Geometry is fixed at 640x480 with a 160x120 bitmap replicated 4x4.
package vga_bw_pkg;

    localparam int   H_ACTIVE       = 640;
    localparam int   V_ACTIVE       = 480;
    localparam int   WORDS_PER_LINE = 10;
    localparam int   FB_WORDS       = 1200;
    localparam int   FB_ADDR_W      = 11;
    localparam logic SYNC_IDLE      = 1'b1;

    // Side-band state carried alongside the RAM read.
    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
        logic border;
    } pipe_t;

    localparam pipe_t PIPE_IDLE = '{active: 1'b0, hsync: SYNC_IDLE,
                                    vsync: SYNC_IDLE, border: 1'b0};

endpackage

// File: rtl/vga_bw_fb_ram.sv
// Simple dual-port bitmap RAM: one write port, one synchronous read port,
// read-before-write on an address collision. Written to map onto Gowin BSRAM.
module vga_bw_fb_ram #(
    parameter int DEPTH  = 1200,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // NOTE: neither the array nor the read register has a reset; adding one
    // would stop the tools from mapping this onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        // The read samples the array before this edge's write lands.
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/vga_bw_fb_reader.sv
// 160x120 1-bpp framebuffer scan-out with 4x4 pixel doubling and a 2-cycle
// pixel/sync pipeline. Define VGA_BW_FB_BORDER_EN to draw a 1-pixel frame border.
module vga_bw_fb_reader
    import vga_bw_pkg::*;
#(
    parameter int FB_W       = 160,
    parameter int FB_H       = 120,
    parameter int WORD_W     = 16,
    parameter int SCALE_LOG2 = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [9:0]           pix_x,
    input  logic [9:0]           pix_y,
    input  logic                 active_in,
    input  logic                 hsync_in,
    input  logic                 vsync_in,
    input  logic                 wr_en,
    input  logic [FB_ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0]    wr_data,
    output logic                 video,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 frame_start,
    output logic                 wr_err
);

    localparam int BIT_W      = $clog2(WORD_W);
    localparam int WORD_SHIFT = SCALE_LOG2 + BIT_W;
    localparam int FB_DEPTH   = (FB_W / WORD_W) * FB_H;

    logic [FB_ADDR_W-1:0] line_idx;
    logic [FB_ADDR_W-1:0] word_idx;
    logic [FB_ADDR_W-1:0] rd_addr;
    logic [WORD_W-1:0]    rd_data;
    logic [BIT_W-1:0]     bit_sel_d, bit_sel_q;
    pipe_t                s1_d, s1_q;
    logic                 video_d, video_q;
    logic                 hsync_q, vsync_q;
    logic                 wr_ok;
    logic                 wr_err_q;
    logic                 vsync_prev_q;
    logic                 frame_start_q;

    always_comb begin
        // NOTE: every signal is given a value at the top of the block, so no
        // path leaves one unassigned and no latch is inferred.
        line_idx  = FB_ADDR_W'(pix_y >> SCALE_LOG2);
        word_idx  = FB_ADDR_W'(pix_x >> WORD_SHIFT);
        // Ten words per line: line*10 as line*8 + line*2, no multiplier.
        rd_addr   = (line_idx << 3) + (line_idx << 1) + word_idx;
        bit_sel_d = BIT_W'(WORD_W - 1) - pix_x[SCALE_LOG2 +: BIT_W];
        s1_d      = '{active: active_in, hsync: hsync_in,
                      vsync: vsync_in, border: 1'b0};
`ifdef VGA_BW_FB_BORDER_EN
        s1_d.border = (pix_x == 10'd0) || (pix_x == 10'(H_ACTIVE - 1)) ||
                      (pix_y == 10'd0) || (pix_y == 10'(V_ACTIVE - 1));
`endif
        video_d   = s1_q.active & (s1_q.border | rd_data[bit_sel_q]);
        wr_ok     = wr_en && (wr_addr < FB_ADDR_W'(FB_WORDS));
    end

    vga_bw_fb_ram #(
        .DEPTH  (FB_DEPTH),
        .WIDTH  (WORD_W),
        .ADDR_W (FB_ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // NOTE: state is updated with non-blocking '<=' so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_sel_q     <= '0;
            s1_q          <= PIPE_IDLE;
            video_q       <= 1'b0;
            hsync_q       <= SYNC_IDLE;
            vsync_q       <= SYNC_IDLE;
            wr_err_q      <= 1'b0;
            vsync_prev_q  <= SYNC_IDLE;
            frame_start_q <= 1'b0;
        end else begin
            bit_sel_q     <= bit_sel_d;
            s1_q          <= s1_d;
            video_q       <= video_d;
            hsync_q       <= s1_q.hsync;
            vsync_q       <= s1_q.vsync;
            wr_err_q      <= wr_en & ~wr_ok;
            vsync_prev_q  <= vsync_in;
            // Taken straight from the input, ahead of the 2-cycle sync delay.
            frame_start_q <= vsync_prev_q & ~vsync_in;
        end
    end

    assign video       = video_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;
    assign wr_err      = wr_err_q;

endmodule

// File: tb/tb_vga_bw_fb_reader.sv
// Self-checking bench for vga_bw_fb_reader: table vectors plus a scoreboard
// queue of expected {video, hsync, vsync} popped two cycles after drive.
module tb_vga_bw_fb_reader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  pix_x, pix_y;
    logic        active_in, hsync_in, vsync_in;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [15:0] wr_data;
    logic        video, hsync, vsync, frame_start, wr_err;

    int total = 0;
    int bad   = 0;

    logic [15:0] fb [1200];
    logic [2:0]  exp_q [$];
    logic        last_vs;
    int          fs_hi;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       act;
        logic       hs;
        logic       vs;
        logic       exp_v;
    } vec_t;

    vec_t tbl [17];

    vga_bw_fb_reader dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .active_in   (active_in),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .video       (video),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start),
        .wr_err      (wr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic border(input int x, input int y);
`ifdef VGA_BW_FB_BORDER_EN
        return (x == 0) || (x == 639) || (y == 0) || (y == 479);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic model_video(input int x, input int y, input logic act);
        logic [15:0] w;
        w = fb[(y / 4) * 10 + x / 64];
        return act & (w[15 - (x / 4) % 16] | border(x, y));
    endfunction

    // One pixel cycle; any write set up by the caller is committed on the same edge.
    task automatic step(input int x, input int y, input logic act,
                        input logic hs, input logic vs, input logic exp_v);
        logic [2:0] e;
        logic       exp_fs;
        pix_x     = 10'(x);
        pix_y     = 10'(y);
        active_in = act;
        hsync_in  = hs;
        vsync_in  = vs;
        exp_q.push_back({exp_v, hs, vs});
        exp_fs  = last_vs & ~vs;
        last_vs = vs;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        if (frame_start) fs_hi++;
        check("frame_start", 16'(frame_start), 16'(exp_fs));
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            check("video_hs_vs", 16'({video, hsync, vsync}), 16'(e));
        end
    endtask

    task automatic wr(input int addr, input logic [15:0] data);
        wr_en   = 1'b1;
        wr_addr = 11'(addr);
        wr_data = data;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        if (addr < 1200) fb[addr] = data;
        check("wr_err", 16'(wr_err), 16'(addr >= 1200));
        exp_q.delete();
    endtask

    initial begin
        tbl[0]  = '{0,   0,   1, 1, 1, 1};
        tbl[1]  = '{1,   1,   1, 0, 1, 1};
        tbl[2]  = '{3,   3,   1, 1, 0, 1};
        tbl[3]  = '{4,   0,   1, 0, 0, 0};
        tbl[4]  = '{3,   4,   1, 1, 1, 0};
        tbl[5]  = '{0,   3,   1, 1, 1, 1};
        tbl[6]  = '{64,  0,   1, 1, 1, 0};
        tbl[7]  = '{639, 479, 1, 0, 1, 1};
        tbl[8]  = '{636, 476, 1, 1, 0, 1};
        tbl[9]  = '{635, 479, 1, 1, 1, 0};
        tbl[10] = '{639, 475, 1, 1, 1, 0};
        tbl[11] = '{637, 478, 1, 0, 0, 1};
        tbl[12] = '{0,   0,   0, 1, 1, 0};
        tbl[13] = '{639, 479, 0, 0, 1, 0};
        tbl[14] = '{1,   200, 1, 1, 1, 0};
        tbl[15] = '{639, 200, 1, 1, 1, 0};
        tbl[16] = '{0,   200, 1, 1, 1, 0};

        foreach (fb[i]) fb[i] = 16'h0000;
        reset_n   = 1'b0;
        pix_x     = '0;
        pix_y     = '0;
        active_in = 1'b0;
        hsync_in  = 1'b1;
        vsync_in  = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        last_vs   = 1'b1;
        fs_hi     = 0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", 16'({video, hsync, vsync, frame_start, wr_err}), 16'b01100);
        reset_n = 1'b1;

        for (int i = 0; i < 1200; i++) wr(i, 16'h0000);
        wr(0, 16'h8000);
        wr(1199, 16'h0001);
        wr(1200, 16'hFFFF);
        @(posedge clk);
        #1;
        check("wr_err_pulse_end", 16'(wr_err), 16'd0);
        wr(2047, 16'hFFFF);

        for (int i = 0; i < 17; i++)
            step(tbl[i].x, tbl[i].y, tbl[i].act, tbl[i].hs, tbl[i].vs,
                 tbl[i].exp_v | (tbl[i].act & border(tbl[i].x, tbl[i].y)));
        for (int i = 0; i < 2; i++) step(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);

        for (int i = 10; i < 20; i++) wr(i, 16'($urandom));
        for (int x = 0; x < 640; x++) begin
            logic hs;
            hs = (x % 97) < 11 ? 1'b0 : 1'b1;
            step(x, 5, 1'b1, hs, 1'b1, model_video(x, 5, 1'b1));
        end

        for (int i = 0; i < 1200; i++) wr(i, 16'hFFFF);
        for (int i = 0; i < 60; i++) begin
            int x, y;
            x = $urandom_range(639);
            y = $urandom_range(479);
            step(x, y, 1'b0, 1'($urandom), 1'($urandom), 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            int x, y;
            x = $urandom_range(639);
            y = $urandom_range(479);
            step(x, y, 1'b1, 1'b1, 1'b1, model_video(x, y, 1'b1));
        end

        // Same-address read and write: the read still returns the old word.
        wr_en   = 1'b1;
        wr_addr = 11'd0;
        wr_data = 16'h0000;
        step(0, 0, 1'b1, 1'b1, 1'b1, model_video(0, 0, 1'b1));
        fb[0] = 16'h0000;
        step(0, 0, 1'b1, 1'b1, 1'b1, model_video(0, 0, 1'b1));
        step(2, 1, 1'b1, 1'b1, 1'b1, model_video(2, 1, 1'b1));
        step(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);

        fs_hi = 0;
        step(10, 10, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(10, 10, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(10, 10, 1'b0, 1'b1, 1'b1, 1'b0);
        check("frame_start_count", 16'(fs_hi), 16'd1);

        // Asynchronous reset mid-line, with video, syncs and wr_err all non-idle.
        step(639, 479, 1'b1, 1'b0, 1'b0, 1'b1);
        step(639, 479, 1'b1, 1'b0, 1'b0, 1'b1);
        wr_en   = 1'b1;
        wr_addr = 11'd1500;
        wr_data = 16'h1234;
        step(639, 479, 1'b1, 1'b0, 1'b0, 1'b1);
        check("pre_reset_wr_err", 16'(wr_err), 16'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midline_reset", 16'({video, hsync, vsync, frame_start, wr_err}), 16'b01100);
        hsync_in  = 1'b1;
        vsync_in  = 1'b1;
        active_in = 1'b0;
        @(posedge clk);
        #1;
        check("reset_held", 16'({video, hsync, vsync, frame_start, wr_err}), 16'b01100);
        reset_n = 1'b1;
        exp_q.delete();
        last_vs = 1'b1;
        step(639, 479, 1'b1, 1'b1, 1'b1, 1'b1);
        step(639, 479, 1'b1, 1'b0, 1'b1, 1'b1);
        step(300, 300, 1'b0, 1'b1, 1'b0, 1'b0);
        step(300, 300, 1'b1, 1'b1, 1'b1, model_video(300, 300, 1'b1));
        step(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
